// File: rtl/xrv_mem_arb_if.sv
// xrv_mem_arb_if: bundle of the fetch (i_*), load/store (d_*) and shared
// memory (m_*) signals around the xrv_mem_arb arbiter.
//   slave  : arbiter view (takes core requests and memory responses,
//            returns readies/rdata and drives the shared bus)
//   master : environment view (core ports plus memory side)
// Parameters: AW address width, DW data width (byte enables = DW/8).
interface xrv_mem_arb_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  localparam int unsigned BEW = DW / 8;

  // fetch port
  logic           i_req;
  logic [AW-1:0]  i_addr;
  logic           i_ready;
  logic [DW-1:0]  i_rdata;
  // load/store port
  logic           d_rd_req;
  logic           d_wr_req;
  logic [AW-1:0]  d_addr;
  logic [BEW-1:0] d_be;
  logic [DW-1:0]  d_wr_data;
  logic           d_rd_ready;
  logic           d_wr_ready;
  logic [DW-1:0]  d_rd_data;
  // shared memory port
  logic           m_req;
  logic           m_we;
  logic [AW-1:0]  m_addr;
  logic [BEW-1:0] m_be;
  logic [DW-1:0]  m_wdata;
  logic           m_ready;
  logic [DW-1:0]  m_rdata;
  // sticky timeout status
  logic           bus_err;

  modport slave (
    input  i_req, i_addr, d_rd_req, d_wr_req, d_addr, d_be, d_wr_data,
           m_ready, m_rdata,
    output i_ready, i_rdata, d_rd_ready, d_wr_ready, d_rd_data,
           m_req, m_we, m_addr, m_be, m_wdata, bus_err
  );

  modport master (
    output i_req, i_addr, d_rd_req, d_wr_req, d_addr, d_be, d_wr_data,
           m_ready, m_rdata,
    input  i_ready, i_rdata, d_rd_ready, d_wr_ready, d_rd_data,
           m_req, m_we, m_addr, m_be, m_wdata, bus_err
  );
endinterface

// File: rtl/xrv_mem_arb.sv
// xrv_mem_arb: shares one single-port memory bus between the core fetch
// port (I) and load/store port (D). Fixed priority D over I, with at most
// D_MAX_BURST consecutive D grants while a fetch is waiting. The grant state
// is registered; the shared-bus mux, readies and rdata are combinational
// from that state so a completion is seen in the same cycle as m_ready.
// Ports:
//   clk  clock
//   rst  asynchronous reset, active-high
//   bus  xrv_mem_arb_if.slave (i_*, d_*, m_*, bus_err)
// Optional feature: define XRV_ARB_TIMEOUT_EN to abort a grant after
// TIMEOUT cycles without m_ready and raise the sticky bus_err flag.
module xrv_mem_arb #(
  parameter int unsigned D_MAX_BURST = 4
`ifdef XRV_ARB_TIMEOUT_EN
  , parameter int unsigned TIMEOUT = 255
`endif
) (
  input logic            clk,
  input logic            rst,
  xrv_mem_arb_if.slave   bus
);

  localparam int unsigned BW = $clog2(D_MAX_BURST + 1);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  state_t        state, state_nxt;
  logic          d_we_q, d_we_nxt;
  logic [BW-1:0] burst_cnt, burst_nxt;

  logic gnt_i, gnt_d, req_c, done_c, tmo_hit;
  logic i_arb, d_wr_arb, d_rd_arb, d_arb;

  assign gnt_i = (state == GNT_I);
  assign gnt_d = (state == GNT_D);

  // Shared request follows the granted requester; the D op type is latched at grant.
  assign req_c  = (gnt_i & bus.i_req) |
                  (gnt_d & (d_we_q ? bus.d_wr_req : bus.d_rd_req));
  assign done_c = req_c & (bus.m_ready | tmo_hit);

  // A requester still holds req in its completion cycle; that is not a new request.
  assign i_arb    = bus.i_req    & ~gnt_i;
  assign d_wr_arb = bus.d_wr_req & ~(gnt_d &  d_we_q);
  assign d_rd_arb = bus.d_rd_req & ~(gnt_d & ~d_we_q);
  assign d_arb    = d_wr_arb | d_rd_arb;

  // Next grant and starvation counter.
  always_comb begin
    state_nxt = state;
    d_we_nxt  = d_we_q;
    burst_nxt = burst_cnt;

    if (!bus.i_req) begin
      burst_nxt = '0;
    end else if (gnt_d && done_c && burst_cnt != BW'(D_MAX_BURST)) begin
      burst_nxt = burst_cnt + BW'(1);
    end

    if (state == IDLE || done_c) begin
      if (d_arb && burst_nxt < BW'(D_MAX_BURST)) begin
        state_nxt = GNT_D;
        d_we_nxt  = d_wr_arb;
      end else if (i_arb) begin
        state_nxt = GNT_I;
        burst_nxt = '0;
      end else if (d_arb) begin
        state_nxt = GNT_D;
        d_we_nxt  = d_wr_arb;
      end else begin
        state_nxt = IDLE;
      end
    end else if (!req_c) begin
      // requester withdrew while granted: drop the grant without a ready
      state_nxt = IDLE;
    end
  end

  // Grant state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      d_we_q    <= 1'b0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      d_we_q    <= d_we_nxt;
      burst_cnt <= burst_nxt;
    end
  end

`ifdef XRV_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] tmo_cnt;
  logic          err_q;

  // Fires on the TIMEOUT-th consecutive cycle of m_req without m_ready.
  assign tmo_hit = req_c & ~bus.m_ready & (tmo_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (tmo_hit) begin
        err_q <= 1'b1;
      end
      if (req_c && !bus.m_ready && !tmo_hit) begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end else begin
        tmo_cnt <= '0;
      end
    end
  end

  assign bus.bus_err = err_q;
`else
  assign tmo_hit     = 1'b0;
  assign bus.bus_err = 1'b0;
`endif

  // Shared bus mux, selected by the registered grant.
  assign bus.m_req   = req_c;
  assign bus.m_we    = gnt_d & d_we_q;
  assign bus.m_addr  = gnt_i ? bus.i_addr : (gnt_d ? bus.d_addr : '0);
  assign bus.m_be    = gnt_i ? '1 : (gnt_d ? bus.d_be : '0);
  assign bus.m_wdata = (gnt_d & d_we_q) ? bus.d_wr_data : '0;

  // Completions; rdata is zero on a timeout abort since m_ready is low then.
  assign bus.i_ready    = gnt_i & done_c;
  assign bus.d_wr_ready = gnt_d &  d_we_q & done_c;
  assign bus.d_rd_ready = gnt_d & ~d_we_q & done_c;
  assign bus.i_rdata    = (gnt_i & req_c & bus.m_ready) ? bus.m_rdata : '0;
  assign bus.d_rd_data  = (gnt_d & ~d_we_q & req_c & bus.m_ready) ? bus.m_rdata : '0;

endmodule

// File: tb/tb_xrv_mem_arb.sv
// tb_xrv_mem_arb: directed bench for xrv_mem_arb. Inputs change 1 time unit
// after the rising edge; outputs are sampled a further time unit later.
module tb_xrv_mem_arb;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  xrv_mem_arb_if #(.AW(32), .DW(32)) bus ();

  xrv_mem_arb #(.D_MAX_BURST(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.i_req     = 1'b0;
    bus.i_addr    = '0;
    bus.d_rd_req  = 1'b0;
    bus.d_wr_req  = 1'b0;
    bus.d_addr    = '0;
    bus.d_be      = '0;
    bus.d_wr_data = '0;
    bus.m_ready   = 1'b0;
    bus.m_rdata   = '0;
  endtask

  // grant code seen on the readies: 0=I, 1=D write, 2=D read, 3=none
  function automatic logic [31:0] gnt_code();
    if (bus.i_ready)    return 32'd0;
    if (bus.d_wr_ready) return 32'd1;
    if (bus.d_rd_ready) return 32'd2;
    return 32'd3;
  endfunction

  int exp_seq [10] = '{1, 2, 1, 2, 0, 1, 2, 1, 2, 0};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_req",   32'(bus.m_req), 32'd0);
    chk("rst_i_ready", 32'(bus.i_ready), 32'd0);
    chk("rst_m_addr",  bus.m_addr, 32'd0);
    chk("rst_m_be",    32'(bus.m_be), 32'd0);
    chk("rst_bus_err", 32'(bus.bus_err), 32'd0);
    rst = 1'b0;

    // m_ready with no request is ignored
    bus.m_ready = 1'b1;
    #1;
    chk("idle_ready", 32'({bus.i_ready, bus.d_rd_ready, bus.d_wr_ready}), 32'd0);
    bus.m_ready = 1'b0;

    // 1: single fetch, two wait cycles
    tick();
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h100;
    #1;
    chk("t1_m_req_n", 32'(bus.m_req), 32'd0);
    tick();
    chk("t1_m_req_n1", 32'(bus.m_req), 32'd1);
    chk("t1_m_addr",   bus.m_addr, 32'h100);
    chk("t1_m_be",     32'(bus.m_be), 32'hF);
    chk("t1_m_we",     32'(bus.m_we), 32'd0);
    chk("t1_wait",     32'(bus.i_ready), 32'd0);
    tick();
    bus.m_ready = 1'b1;
    bus.m_rdata = 32'hCAFE_0001;
    #1;
    chk("t1_i_ready", 32'(bus.i_ready), 32'd1);
    chk("t1_i_rdata", bus.i_rdata, 32'hCAFE_0001);
    chk("t1_d_rdy",   32'(bus.d_rd_ready), 32'd0);
    tick();
    bus.i_req   = 1'b0;
    bus.m_ready = 1'b0;
    #1;
    chk("t1_one_pulse", 32'(bus.i_ready), 32'd0);
    chk("t1_idle",      32'(bus.m_req), 32'd0);

    // 2: simultaneous I and D read, D first then I with no gap
    tick();
    bus.i_req    = 1'b1;
    bus.i_addr   = 32'h300;
    bus.d_rd_req = 1'b1;
    bus.d_addr   = 32'h400;
    bus.d_be     = 4'h3;
    tick();
    chk("t2_d_addr", bus.m_addr, 32'h400);
    chk("t2_d_be",   32'(bus.m_be), 32'h3);
    bus.m_ready = 1'b1;
    bus.m_rdata = 32'h11;
    #1;
    chk("t2_d_rdy",   32'(bus.d_rd_ready), 32'd1);
    chk("t2_d_data",  bus.d_rd_data, 32'h11);
    chk("t2_i_hold",  32'(bus.i_ready), 32'd0);
    tick();
    bus.d_rd_req = 1'b0;
    bus.m_rdata  = 32'h22;
    #1;
    chk("t2_i_m_req", 32'(bus.m_req), 32'd1);
    chk("t2_i_addr",  bus.m_addr, 32'h300);
    chk("t2_i_rdy",   32'(bus.i_ready), 32'd1);
    chk("t2_i_data",  bus.i_rdata, 32'h22);
    tick();
    clear_inputs();
    #1;
    chk("t2_idle", 32'(bus.m_req), 32'd0);

    // 3: continuous D traffic with a waiting fetch -> 4 D grants, then 1 I
    tick();
    bus.i_req     = 1'b1;
    bus.i_addr    = 32'h500;
    bus.d_rd_req  = 1'b1;
    bus.d_wr_req  = 1'b1;
    bus.d_addr    = 32'h600;
    bus.d_be      = 4'hF;
    bus.d_wr_data = 32'hAA;
    bus.m_ready   = 1'b1;
    tick();
    for (int k = 0; k < 10; k++) begin
      #1;
      chk($sformatf("t3_seq%0d", k), gnt_code(), 32'(exp_seq[k]));
      tick();
    end
    clear_inputs();
    tick();
    chk("t3_idle", 32'(bus.m_req), 32'd0);

    // 4: write and read together -> write first, then read
    bus.d_wr_req  = 1'b1;
    bus.d_rd_req  = 1'b1;
    bus.d_addr    = 32'h200;
    bus.d_be      = 4'hF;
    bus.d_wr_data = 32'h55;
    tick();
    chk("t4_we",    32'(bus.m_we), 32'd1);
    chk("t4_addr",  bus.m_addr, 32'h200);
    chk("t4_wdata", bus.m_wdata, 32'h55);
    bus.m_ready = 1'b1;
    bus.m_rdata = 32'h77;
    #1;
    chk("t4_wr_rdy", 32'(bus.d_wr_ready), 32'd1);
    chk("t4_rd_rdy", 32'(bus.d_rd_ready), 32'd0);
    tick();
    bus.d_wr_req = 1'b0;
    #1;
    chk("t4_rd_we",   32'(bus.m_we), 32'd0);
    chk("t4_rd_rdy2", 32'(bus.d_rd_ready), 32'd1);
    chk("t4_rd_data", bus.d_rd_data, 32'h77);
    tick();
    clear_inputs();
    #1;

    // 5: asynchronous reset in the middle of a D grant
    bus.d_wr_req  = 1'b1;
    bus.d_addr    = 32'h700;
    bus.d_wr_data = 32'h99;
    tick();
    chk("t5_granted", 32'(bus.m_req), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("t5_m_req",  32'(bus.m_req), 32'd0);
    chk("t5_m_addr", bus.m_addr, 32'd0);
    chk("t5_m_we",   32'(bus.m_we), 32'd0);
    chk("t5_wdata",  bus.m_wdata, 32'd0);
    tick();
    clear_inputs();
    rst = 1'b0;
    tick();
    chk("t5_idle", 32'(bus.m_req), 32'd0);

`ifdef XRV_ARB_TIMEOUT_EN
    // 6: m_ready stuck low -> abort on cycle 255 of the grant
    bus.i_req   = 1'b1;
    bus.i_addr  = 32'h900;
    bus.m_rdata = 32'hDEAD_BEEF;
    tick();
    repeat (253) tick();
    chk("t6_c254",     32'(bus.i_ready), 32'd0);
    tick();
    chk("t6_c255",     32'(bus.i_ready), 32'd1);
    chk("t6_rdata0",   bus.i_rdata, 32'd0);
    chk("t6_err_pre",  32'(bus.bus_err), 32'd0);
    tick();
    bus.i_req = 1'b0;
    #1;
    chk("t6_err",      32'(bus.bus_err), 32'd1);
    chk("t6_released", 32'(bus.m_req), 32'd0);
    bus.d_rd_req = 1'b1;
    bus.d_addr   = 32'hA00;
    tick();
    bus.m_ready = 1'b1;
    #1;
    chk("t6_next_rdy",  32'(bus.d_rd_ready), 32'd1);
    chk("t6_next_data", bus.d_rd_data, 32'hDEAD_BEEF);
    chk("t6_sticky",    32'(bus.bus_err), 32'd1);
    tick();
    clear_inputs();
`else
    chk("no_bus_err", 32'(bus.bus_err), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
